// File: rtl/f_mon_pkg.sv
// Shared types and default constants for the F-function event monitor.
// The state encoding is fixed; the unused code 2'b11 falls back to LOW.
package f_mon_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int HOLD_LIMIT_DEF = 4;
  localparam int RUN_W_DEF      = 4;

  typedef enum logic [1:0] {
    LOW   = 2'b00,
    RUN   = 2'b01,
    ALARM = 2'b10
  } mon_state_e;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser for asynchronous combinational nets.
// Reset is asynchronous and active-low; both stages clear to 0.
module sync2_ff (
  input  logic clock,
  input  logic reset_b,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // metastability stage followed by the clean output stage
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/f_event_monitor.sv
// Synchronises raw F, produces edge pulses, a saturating rise counter
// and a hold-too-long alarm FSM driven by the run length of f_sync.
module f_event_monitor
  import f_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int HOLD_LIMIT = HOLD_LIMIT_DEF,
  parameter int RUN_W      = RUN_W_DEF
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             f_in,
  input  logic             enable,
  input  logic             clear,
  output logic             f_sync,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_count,
  output logic             count_sat,
  output logic [RUN_W-1:0] run_len,
  output logic             hold_alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX   = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(HOLD_LIMIT);

  logic             f_sync_s;
  logic             f_prev_r;
  logic             rise_s;
  logic             fall_s;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;
  mon_state_e       state_r;
  mon_state_e       state_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_s;
  logic [RUN_W-1:0] nxt_s;

  sync2_ff u_sync (
    .clock   (clock),
    .reset_b (reset_b),
    .d       (f_in),
    .q       (f_sync_s)
  );

  // one-cycle history of f_sync for edge detection
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      f_prev_r <= 1'b0;
    end else begin
      f_prev_r <= f_sync_s;
    end
  end

  assign rise_s = f_sync_s & ~f_prev_r;
  assign fall_s = ~f_sync_s & f_prev_r;

  // saturating rise counter; sat flag sets on the edge the count hits all-ones
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (enable && rise_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
      sat_r <= sat_r | (cnt_r == (CNT_MAX - CNT_W'(1)));
    end else begin
      cnt_r <= cnt_r;
      sat_r <= sat_r;
    end
  end

  assign nxt_s = (run_r == RUN_MAX) ? run_r : run_r + RUN_W'(1);

  // next-state and run-length logic
  always_comb begin
    state_s = LOW;
    run_s   = {RUN_W{1'b0}};
    if (clear || !enable) begin
      state_s = LOW;
      run_s   = {RUN_W{1'b0}};
    end else begin
      case (state_r)
        LOW: begin
          if (f_sync_s) begin
            run_s   = RUN_W'(1);
            state_s = (HOLD_LIMIT == 1) ? ALARM : RUN;
          end else begin
            run_s   = {RUN_W{1'b0}};
            state_s = LOW;
          end
        end
        RUN: begin
          if (f_sync_s) begin
            run_s   = nxt_s;
            state_s = (nxt_s >= RUN_LIMIT) ? ALARM : RUN;
          end else begin
            run_s   = {RUN_W{1'b0}};
            state_s = LOW;
          end
        end
        ALARM: begin
          if (f_sync_s) begin
            run_s   = nxt_s;
            state_s = ALARM;
          end else begin
            run_s   = {RUN_W{1'b0}};
            state_s = LOW;
          end
        end
        default: begin
          run_s   = {RUN_W{1'b0}};
          state_s = LOW;
        end
      endcase
    end
  end

  // FSM state and run-length registers
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= LOW;
      run_r   <= {RUN_W{1'b0}};
    end else begin
      state_r <= state_s;
      run_r   <= run_s;
    end
  end

  assign f_sync      = f_sync_s;
  assign rise_pulse  = rise_s;
  assign fall_pulse  = fall_s;
  assign event_count = cnt_r;
  assign count_sat   = sat_r;
  assign run_len     = run_r;
  assign hold_alarm  = (state_r == ALARM);

endmodule
